mem_wb_stage: RTL and testbench

- MEM/WB pipeline register and write-back stage of the 5-stage pipelined CPU; consumes the write-back control pair (MemtoReg, RegWrite) produced by the WB control decoder and carried down the pipe.
- Latches per-instruction results, selects ALU result vs. load data, and drives the register-file write port exactly once per instruction.
- Also exports a forwarding source for the EX-stage forwarding unit and a saturating retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 69 ++++++
 tb/tb_mem_wb_stage.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with write-back mux, forwarding source
// and saturating retired-instruction counter.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_rdata,
  input  logic [REG_AW-1:0] in_rd,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              wb_retire,
  output logic [CNT_W-1:0]  retired_count
);
  logic              v, m2r, rw, fresh;
  logic [DATA_W-1:0] alu, mdata, wData;
  logic [REG_AW-1:0] rd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v             <= 1'b0;
      m2r           <= 1'b0;
      rw            <= 1'b0;
      fresh         <= 1'b0;
      alu           <= '0;
      mdata         <= '0;
      rd            <= '0;
      retired_count <= '0;
    end else begin
      if (flush) begin
        v     <= 1'b0;
        rw    <= 1'b0;
        m2r   <= 1'b0;
        fresh <= 1'b0;
      end else if (stall) begin
        fresh <= 1'b0;
      end else begin
        v     <= in_valid;
        fresh <= in_valid;
        m2r   <= in_mem_to_reg;
        rw    <= in_reg_write;
        alu   <= in_alu_result;
        mdata <= in_mem_rdata;
        rd    <= in_rd;
      end
      if (wb_retire && retired_count != '1) retired_count <= retired_count + 1'b1;
    end
  end
  // fresh marks the first WB cycle so a stalled instruction writes/retires once
  assign wData     = m2r ? mdata : alu;
  assign rf_we     = v & rw & fresh & (rd != '0);
  assign rf_waddr  = rd;
  assign rf_wdata  = wData;
  assign fwd_valid = v & rw & (rd != '0);
  assign fwd_rd    = rd;
  assign fwd_data  = wData;
  assign wb_retire = v & fresh;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized check of mem_wb_stage against an instruction-level
// model (which instruction sits in WB and for how many cycles).
module tb_mem_wb_stage;
  logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        inValid = 1'b0, inMemToReg = 1'b0, inRegWrite = 1'b0;
  logic [31:0] inAlu = '0, inMdata = '0;
  logic [4:0]  inRd = '0;
  logic        rfWe, fwdValid, wbRetire;
  logic [4:0]  rfWaddr, fwdRd;
  logic [31:0] rfWdata, fwdData, retiredCount;
  logic        sWe, sFv, sRet;
  logic [4:0]  sWa, sFr;
  logic [31:0] sWd, sFd;
  logic [3:0]  satCount;
  int errors = 0, checks = 0;

  typedef struct {
    bit valid, m2r, rw;
    bit [31:0] alu, mdata;
    bit [4:0] rd;
  } instT;
  instT slot;
  int age, retired;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(inValid), .in_mem_to_reg(inMemToReg), .in_reg_write(inRegWrite),
    .in_alu_result(inAlu), .in_mem_rdata(inMdata), .in_rd(inRd),
    .rf_we(rfWe), .rf_waddr(rfWaddr), .rf_wdata(rfWdata),
    .fwd_valid(fwdValid), .fwd_rd(fwdRd), .fwd_data(fwdData),
    .wb_retire(wbRetire), .retired_count(retiredCount));

  mem_wb_stage #(.CNT_W(4)) dutSat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(inValid), .in_mem_to_reg(inMemToReg), .in_reg_write(inRegWrite),
    .in_alu_result(inAlu), .in_mem_rdata(inMdata), .in_rd(inRd),
    .rf_we(sWe), .rf_waddr(sWa), .rf_wdata(sWd),
    .fwd_valid(sFv), .fwd_rd(sFr), .fwd_data(sFd),
    .wb_retire(sRet), .retired_count(satCount));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    slot = '{default: 0};
    age = 1;
    retired = 0;
  endtask

  task automatic checkAll();
    bit [31:0] wd;
    bit writes;
    wd = slot.m2r ? slot.mdata : slot.alu;
    writes = slot.valid && slot.rw && slot.rd != 0;
    check("rf_we", rfWe, writes && age == 0);
    check("fwd_valid", fwdValid, writes);
    check("wb_retire", wbRetire, slot.valid && age == 0);
    check("retired_count", retiredCount, retired);
    check("sat_count", satCount, retired > 15 ? 15 : retired);
    if (slot.valid) begin
      check("rf_waddr", rfWaddr, slot.rd);
      check("rf_wdata", rfWdata, wd);
      check("fwd_rd", fwdRd, slot.rd);
      check("fwd_data", fwdData, wd);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (slot.valid && age == 0) retired++;
    if (flush) begin
      slot.valid = 0;
      age = 1;
    end else if (stall) age++;
    else begin
      slot = '{inValid, inMemToReg, inRegWrite, inAlu, inMdata, inRd};
      age = 0;
    end
    @(negedge clk);
    checkAll();
  endtask

  task automatic drive(input bit v, input bit m2r, input bit rw, input bit [31:0] alu,
                       input bit [31:0] md, input bit [4:0] rd, input bit st, input bit fl);
    inValid = v; inMemToReg = m2r; inRegWrite = rw;
    inAlu = alu; inMdata = md; inRd = rd; stall = st; flush = fl;
  endtask

  initial begin
    modelReset();
    repeat (2) @(negedge clk);
    check("reset_we", rfWe, 0);
    check("reset_wdata", rfWdata, 0);
    check("reset_count", retiredCount, 0);
    rst_n = 1'b1;
    // basic ALU write then count update
    drive(1, 0, 1, 32'h1234, 32'h0, 5, 0, 0); step();
    check("first_we", rfWe, 1);
    check("first_wdata", rfWdata, 32'h1234);
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    check("first_count", retiredCount, 1);
    // load select
    drive(1, 1, 1, 32'h10, 32'hDEADBEEF, 8, 0, 0); step();
    check("load_fwd", fwdData, 32'hDEADBEEF);
    // stall hold: write once, forward for all four cycles
    drive(1, 0, 1, 32'h77, 32'h0, 3, 0, 0); step();
    drive(1, 0, 1, 32'h99, 32'h0, 9, 1, 0);
    repeat (3) begin step(); check("stall_fwd", fwdValid, 1); end
    // rd=0, branch, bubble
    drive(1, 0, 1, 32'h5, 0, 0, 0, 0); step();
    drive(1, 1, 0, 32'h5, 32'h6, 4, 0, 0); step();
    drive(0, 0, 1, 32'h5, 32'h6, 4, 0, 0); step();
    // flush beats stall
    drive(1, 0, 1, 32'hAA, 0, 7, 0, 0); step();
    drive(1, 0, 1, 32'hBB, 0, 6, 1, 1); step();
    check("flush_we", rfWe, 0);
    // async reset while stalled
    drive(1, 0, 1, 32'hCC, 0, 2, 0, 0); step();
    drive(1, 0, 1, 32'hCC, 0, 2, 1, 0); step();
    #2 rst_n = 1'b0;
    #1;
    check("areset_fwd", fwdValid, 0);
    check("areset_count", retiredCount, 0);
    check("areset_waddr", rfWaddr, 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    // saturation of the 4-bit counter
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 1, i, 0, 1, 0, 0); step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    check("sat_stop", satCount, 15);
    check("nosat_count", retiredCount, 17);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
            $urandom, $urandom, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
